// File: rtl/mg_round_engine.sv
// mg_round_engine: iterative MacGuffin Feistel round engine, one round per clock
package mg_pkg;
  localparam logic [127:0] MG_SBOX [8] = '{
    128'h2c5e93b1d6047fa8e31b4c960a7d58f2,
    128'h8d17e4a2b9306fc5527ae18b04dc396f,
    128'hf0934bd81e6c27a5c83b59e6071da4f2,
    128'h4e1b7c2986fad0536a92e7c41bd05f38,
    128'hb27d05e8c4a913f6397e0d2cba5846f1,
    128'h61c9f2083eb7d45aa0e5397c1f82b64d,
    128'hd8365fa12c7be049847f1a3d60c2e95b,
    128'h1a7c3e95f06bd28453e9c01ab7f4268d
  };
  localparam logic [3:0] MG_SBOX_IN_SEL [8][6] = '{
    '{4'd2, 4'd5, 4'd6, 4'd9, 4'd11, 4'd13},
    '{4'd1, 4'd4, 4'd7, 4'd10, 4'd8, 4'd14},
    '{4'd3, 4'd6, 4'd8, 4'd13, 4'd0, 4'd15},
    '{4'd12, 4'd14, 4'd1, 4'd2, 4'd4, 4'd10},
    '{4'd0, 4'd10, 4'd3, 4'd14, 4'd6, 4'd12},
    '{4'd7, 4'd8, 4'd12, 4'd15, 4'd1, 4'd5},
    '{4'd9, 4'd15, 4'd5, 4'd11, 4'd2, 4'd7},
    '{4'd11, 4'd13, 4'd0, 4'd4, 4'd3, 4'd9}
  };
  localparam logic [3:0] MG_SBOX_OUT_SEL [8][2] = '{
    '{4'd15, 4'd2}, '{4'd9, 4'd4}, '{4'd0, 4'd11}, '{4'd13, 4'd6},
    '{4'd7, 4'd10}, '{4'd3, 4'd12}, '{4'd5, 4'd14}, '{4'd1, 4'd8}
  };
endpackage

module mg_round_engine #(
  parameter int ROUNDS = 32,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      block_i,
  input  logic             decrypt_i,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [47:0]      rk_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      block_o,
  output logic             busy
);
  import mg_pkg::*;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] PEN  = IDX_W'(ROUNDS - 2);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, rk_idx_q, rk_idx_d;
  logic [63:0]      data_q, data_d;
  logic             dec_q, dec_d;
  logic [47:0]      src;
  logic [15:0]      a, b, c, f;
  logic [15:0]      fp [8];
  assign src = dec_q ? data_q[63:16] : data_q[47:0];
  assign a = src[47:32] ^ rk_i[47:32];
  assign b = src[31:16] ^ rk_i[31:16];
  assign c = src[15:0] ^ rk_i[15:0];
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] si;
    logic [1:0] so;
    assign si = {a[MG_SBOX_IN_SEL[j][0]], a[MG_SBOX_IN_SEL[j][1]],
                 b[MG_SBOX_IN_SEL[j][2]], b[MG_SBOX_IN_SEL[j][3]],
                 c[MG_SBOX_IN_SEL[j][4]], c[MG_SBOX_IN_SEL[j][5]]};
    assign so = MG_SBOX[j][{si, 1'b0} +: 2];
    assign fp[j] = (16'(so[1]) << MG_SBOX_OUT_SEL[j][0]) | (16'(so[0]) << MG_SBOX_OUT_SEL[j][1]);
  end
  assign f = fp[0] | fp[1] | fp[2] | fp[3] | fp[4] | fp[5] | fp[6] | fp[7];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rk_idx_d = rk_idx_q;
    data_d   = data_q;
    dec_d    = dec_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = RUN;
        data_d   = block_i;
        dec_d    = decrypt_i;
        cnt_d    = '0;
        rk_idx_d = decrypt_i ? LAST : '0;
      end
      RUN: begin
        data_d   = dec_q ? {data_q[15:0] ^ f, data_q[63:16]} : {data_q[47:0], data_q[63:48] ^ f};
        state_d  = cnt_q == LAST ? DONE : RUN;
        cnt_d    = cnt_q == LAST ? cnt_q : cnt_q + IDX_W'(1);
        rk_idx_d = cnt_q == LAST ? rk_idx_q : dec_q ? PEN - cnt_q : cnt_q + IDX_W'(1);
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rk_idx_q <= '0;
      data_q   <= '0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rk_idx_q <= rk_idx_d;
      data_q   <= data_d;
      dec_q    <= dec_d;
    end
  end
  assign in_ready  = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign block_o   = data_q;
  assign rk_idx    = rk_idx_q;
endmodule

// File: tb/tb_mg_round_engine.sv
// tb_mg_round_engine: directed self-checking bench for mg_round_engine
module tb_mg_round_engine;
  import mg_pkg::*;
  localparam int R = 32;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, decrypt_i = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, busy;
  logic [63:0] block_i = '0, block_o, res, exp_v, ct;
  logic [4:0]  rk_idx;
  logic [47:0] rk_i;
  logic [47:0] kram [R];
  logic        seen;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign rk_i = kram[rk_idx];
  mg_round_engine #(.ROUNDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .block_i(block_i), .decrypt_i(decrypt_i), .rk_idx(rk_idx), .rk_i(rk_i),
    .out_valid(out_valid), .out_ready(out_ready), .block_o(block_o), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] mf(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [15:0] r;
    logic [5:0]  idx;
    logic [1:0]  v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      idx = {a[MG_SBOX_IN_SEL[j][0]], a[MG_SBOX_IN_SEL[j][1]], b[MG_SBOX_IN_SEL[j][2]],
             b[MG_SBOX_IN_SEL[j][3]], c[MG_SBOX_IN_SEL[j][4]], c[MG_SBOX_IN_SEL[j][5]]};
      v = 2'(MG_SBOX[j] >> (2 * int'(idx)));
      r[MG_SBOX_OUT_SEL[j][0]] = v[1];
      r[MG_SBOX_OUT_SEL[j][1]] = v[0];
    end
    return r;
  endfunction
  function automatic logic [63:0] model(input logic [63:0] blk, input logic dec);
    logic [15:0] x0, x1, x2, x3, t;
    logic [47:0] k;
    {x0, x1, x2, x3} = blk;
    for (int r = 0; r < R; r++) begin
      k = kram[dec ? R - 1 - r : r];
      if (!dec) begin
        t = x0 ^ mf(x1 ^ k[47:32], x2 ^ k[31:16], x3 ^ k[15:0]);
        x0 = x1; x1 = x2; x2 = x3; x3 = t;
      end else begin
        t = x3 ^ mf(x0 ^ k[47:32], x1 ^ k[31:16], x2 ^ k[15:0]);
        x3 = x2; x2 = x1; x1 = x0; x0 = t;
      end
    end
    return {x0, x1, x2, x3};
  endfunction
  task automatic run_block(input logic [63:0] blk, input logic dec, input logic glitch, output logic [63:0] r);
    check("accept_ready", in_ready, 1);
    block_i = blk; decrypt_i = dec; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; decrypt_i = ~dec;
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    for (int i = 0; i < R; i++) begin
      check("rk_idx_trace", rk_idx, dec ? R - 1 - i : i);
      check("early_out_valid", out_valid, 0);
      if (glitch) begin
        in_valid = i >= 3 && i < 7;
        block_i = 64'h1111_2222_3333_4444;
      end
      tick;
    end
    in_valid = 1'b0;
    check("latency_out_valid", out_valid, 1);
    r = block_o;
  endtask
  initial begin
    for (int i = 0; i < R; i++) kram[i] = '0;
    tick;
    tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_block_o", block_o, 0);
    check("rst_rk_idx", rk_idx, 0);
    rst_n = 1'b1;
    tick;
    check("idle_in_ready", in_ready, 1);
    exp_v = model(64'h0123_4567_89AB_CDEF, 1'b0);
    run_block(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, res);
    check("enc_zero_key", res, exp_v);
    tick;
    check("idle_after_done", in_ready, 1);
    check("valid_drop", out_valid, 0);
    for (int i = 0; i < R; i++) kram[i] = {16'($urandom), 32'($urandom)};
    exp_v = model(64'hFEDC_BA98_7654_3210, 1'b0);
    run_block(64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, res);
    check("enc_rand_glitch", res, exp_v);
    ct = res;
    tick;
    run_block(ct, 1'b1, 1'b0, res);
    check("round_trip", res, 64'hFEDC_BA98_7654_3210);
    tick;
    out_ready = 1'b0;
    exp_v = model(64'h0F1E_2D3C_4B5A_6978, 1'b0);
    run_block(64'h0F1E_2D3C_4B5A_6978, 1'b0, 1'b0, res);
    check("bp_result", res, exp_v);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_out_valid", out_valid, 1);
      check("bp_block_o", block_o, exp_v);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    block_i = 64'h5555_AAAA_0000_FFFF; decrypt_i = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (15) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_block_o", block_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= out_valid;
      tick;
    end
    check("midrun_rst_no_valid", seen, 0);
    exp_v = model(64'hA5A5_5A5A_C3C3_3C3C, 1'b0);
    run_block(64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 1'b0, res);
    check("post_rst_result", res, exp_v);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
